mgmt_sram_arbiter: RTL and testbench
====================================

# mgmt_sram_arbiter

Parametrised single-port SRAM arbiter for the management SoC. It sits between the CPU's DFFRAM port and the DFFRAM macro, and adds a second, read-only requester (housekeeping SPI) on the same clock. It generalises the fixed 8-bit-address, 32-bit, CPU-only RAM hookup in three ways: parametrised width and depth, selectable arbitration mode, and a starvation guard. Word reads and byte-masked writes from the CPU reach the RAM unchanged unless a housekeeping read wins the cycle, in which case the CPU is stalled.

## Interface
Parameters:
- AW, 8: RAM word-address width (depth = 2^AW words).
- DW, 32: data width, a multiple of 8.
- NB, DW/8: byte-enable count. Derived; do not override.
- MODE, 0: arbitration mode. 0 = CPU priority with starvation guard; 1 = round-robin.
- STARVE_MAX, 4: MODE 0 only. Number of consecutive denied RO cycles after which RO wins a conflict. 0 means RO always wins.

Ports:
- core_clk  in  1  sole clock.
- core_rstn  in  1  asynchronous, active-low reset.
- cpu_en  in  1  CPU access request.
- cpu_we  in  NB  byte write enables; all zero means read.
- cpu_a  in  AW  CPU word address.
- cpu_di  in  DW  CPU write data.
- cpu_do  out  DW  CPU read data; equals ram_do.
- cpu_stall  out  1  CPU access not taken this cycle; hold request.
- cpu_dv  out  1  cpu_do valid; pulses one cycle after an accepted read.
- ro_req  in  1  housekeeping read request.
- ro_addr  in  AW  housekeeping word address.
- ro_gnt  out  1  housekeeping request accepted this cycle.
- ro_data  out  DW  held housekeeping read data.
- ro_valid  out  1  ro_data updated this cycle; one-cycle pulse.
- ram_en, ram_we[NB], ram_a[AW], ram_di[DW]  out  drive the DFFRAM macro.
- ram_do  in  DW  DFFRAM read data, valid the cycle after a read.

## Operation
- One RAM access per cycle. A request is accepted when its owner wins the grant.
- The CPU is accepted when cpu_en && !cpu_stall. cpu_stall = cpu_en && ro_gnt (combinational).
- ro_gnt = ro_req && (RO wins, or cpu_en is low).
- RAM drive when the CPU is granted: ram_en=1, ram_we=cpu_we, ram_a=cpu_a, ram_di=cpu_di.
- RAM drive when RO is granted: ram_en=1, ram_we=0, ram_a=ro_addr, ram_di=0.
- RAM drive when idle: all ram_* = 0.
- MODE 0, starve counter:
  - Width is clog2(STARVE_MAX+1); saturates at STARVE_MAX.
  - Increments each cycle ro_req && !ro_gnt.
  - Clears on ro_gnt or when ro_req is low.
  - On conflict (cpu_en && ro_req), RO wins iff the counter == STARVE_MAX.
- MODE 1, round-robin:
  - 1-bit last register, updated on every grant (0 = CPU, 1 = RO).
  - On conflict, the requester not equal to last wins.
  - Reset value is RO, so the CPU wins the first conflict.
- Read return, CPU: rd_cpu_q <= accepted CPU read; cpu_dv = rd_cpu_q.
- Read return, RO: rd_ro_q <= ro_gnt. When rd_ro_q=1, ro_data <= ram_do and ro_valid=1. Otherwise ro_data holds.
- CPU writes produce no cpu_dv. Byte lanes with cpu_we[i]=0 are untouched by the macro.
- Requesters hold their address and data while stalled or while ro_req is pending. A change of ro_addr before ro_gnt is permitted; the address sampled at grant is the one used.
- Reset values (async, core_rstn low): cpu_dv=0, ro_valid=0, ro_data=0, starve counter=0, last=RO. Combinational outputs follow the inputs.
- Reset asserted mid-read: the pending dv/valid is dropped and no late pulse appears after release.

## Timing
- CPU read latency: 1 cycle after acceptance (cpu_dv, cpu_do).
- RO read latency: 1 cycle after ro_gnt (ro_valid, ro_data). ro_data then holds indefinitely.
- Back-to-back accesses at full throughput, with no bubble between grants.
- Worst-case RO wait in MODE 0: STARVE_MAX+1 cycles under continuous cpu_en.
- Worst-case CPU wait in MODE 1: 1 cycle.
- No combinational path from ram_do to any grant or stall signal.

## Test plan
- Reset: hold core_rstn=0 with requests active. Required: cpu_dv=0, ro_valid=0, ro_data=0. After release, the first conflict in MODE 1 grants the CPU.
- CPU write then read, MODE 0:
  - Write cpu_a=0x10, cpu_di=0xDEADBEEF, cpu_we=4'b1111.
  - Write cpu_we=4'b0001, cpu_di=0x000000AA.
  - Read 0x10. Required: cpu_dv next cycle with cpu_do=0xDEADBEAA.
- Starvation, MODE 0, STARVE_MAX=4:
  - cpu_en held high; ro_req=1 with ro_addr=0x10.
  - Required: CPU granted for 4 cycles, cpu_stall=1 on cycle 5 with ro_gnt=1.
  - Next cycle: ro_valid=1 with ro_data=0xDEADBEAA. The counter is then 0 again.
- Round-robin, MODE 1: continuous cpu_en and ro_req. Required: grants alternate CPU, RO, CPU, RO, and cpu_dv/ro_valid alternate accordingly.
- RO only with cpu_en=0: ro_req for addresses 0x00 then 0xFF on consecutive cycles. Required: two ro_gnt pulses, two ro_valid pulses on consecutive cycles with the matching data, and ro_data holding the 0xFF word afterwards.
- Mid-read reset: assert core_rstn low in the cycle after a CPU read grant. Required: cpu_dv never pulses, and ro_data=0.

Source files
------------

// File: rtl/mgmt_sram_arbiter.sv
// Single-port SRAM arbiter between the CPU DFFRAM port and a read-only housekeeping requester.
// MODE 0 gives the CPU priority with a starvation guard; MODE 1 alternates on conflict.
module mgmt_sram_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 32,
  parameter int unsigned NB         = DW / 8,
  parameter int unsigned MODE       = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          core_clk,
  input  logic          core_rstn,
  // CPU port
  input  logic          cpu_en,
  input  logic [NB-1:0] cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_di,
  output logic [DW-1:0] cpu_do,
  output logic          cpu_stall,
  output logic          cpu_dv,
  // Housekeeping read-only port
  input  logic          ro_req,
  input  logic [AW-1:0] ro_addr,
  output logic          ro_gnt,
  output logic [DW-1:0] ro_data,
  output logic          ro_valid,
  // DFFRAM macro
  output logic          ram_en,
  output logic [NB-1:0] ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  // A zero-width counter is illegal, so STARVE_MAX=0 keeps one bit pinned at zero.
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          last_q, last_d;
  logic          rd_cpu_q, rd_cpu_d;
  logic          rd_ro_q;
  logic [DW-1:0] ro_hold_q;
  logic          ro_wins;
  logic          cpu_gnt;

  // Grant decision depends only on registered state and request inputs, never on ram_do.
  always_comb begin
    ro_wins = 1'b0;
    if (MODE == 0) begin
      ro_wins = (starve_q == StarveMax);
    end else begin
      ro_wins = ~last_q;
    end
    ro_gnt    = ro_req && (ro_wins || !cpu_en);
    cpu_stall = cpu_en && ro_gnt;
    cpu_gnt   = cpu_en && !ro_gnt;
  end

  always_comb begin
    ram_en = cpu_gnt || ro_gnt;
    ram_we = '0;
    ram_a  = '0;
    ram_di = '0;
    if (ro_gnt) begin
      ram_a = ro_addr;
    end else if (cpu_gnt) begin
      ram_we = cpu_we;
      ram_a  = cpu_a;
      ram_di = cpu_di;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!ro_req || ro_gnt) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + SW'(1);
    end
    last_d = last_q;
    if (ro_gnt) begin
      last_d = 1'b1;
    end else if (cpu_gnt) begin
      last_d = 1'b0;
    end
    rd_cpu_d = cpu_gnt && (cpu_we == '0);
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      starve_q  <= '0;
      last_q    <= 1'b1;
      rd_cpu_q  <= 1'b0;
      rd_ro_q   <= 1'b0;
      ro_hold_q <= '0;
    end else begin
      starve_q <= starve_d;
      last_q   <= last_d;
      rd_cpu_q <= rd_cpu_d;
      rd_ro_q  <= ro_gnt;
      if (rd_ro_q) begin
        ro_hold_q <= ram_do;
      end
    end
  end

  // ro_data shows the fresh word during the ro_valid cycle, then holds it.
  always_comb begin
    cpu_do   = ram_do;
    cpu_dv   = rd_cpu_q;
    ro_valid = rd_ro_q;
    ro_data  = rd_ro_q ? ram_do : ro_hold_q;
  end

endmodule

// File: tb/tb_mgmt_sram_arbiter.sv
// Bench for mgmt_sram_arbiter: MODE 0 and MODE 1 instances share stimulus, each with its own
// DFFRAM model; outputs are compared against a transaction-level reference model.
module tb_mgmt_sram_arbiter;

  localparam int unsigned SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, cpu_en, ro_req, mem_init;
  logic [3:0]  cpu_we;
  logic [7:0]  cpu_a, ro_addr;
  logic [31:0] cpu_di;

  logic [31:0] cpu_do   [2];
  logic        cpu_stall[2];
  logic        cpu_dv   [2];
  logic        ro_gnt   [2];
  logic [31:0] ro_data  [2];
  logic        ro_valid [2];
  logic        ram_en   [2];
  logic [3:0]  ram_we   [2];
  logic [7:0]  ram_a    [2];
  logic [31:0] ram_di   [2];
  logic [31:0] ram_do   [2];

  function automatic logic [31:0] pat(input int unsigned i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hC3, b, ~b, 8'h5A};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [256];

    mgmt_sram_arbiter #(
      .AW(8), .DW(32), .MODE(g), .STARVE_MAX(SM)
    ) u_dut (
      .core_clk (clk),
      .core_rstn(rstn),
      .cpu_en   (cpu_en),
      .cpu_we   (cpu_we),
      .cpu_a    (cpu_a),
      .cpu_di   (cpu_di),
      .cpu_do   (cpu_do[g]),
      .cpu_stall(cpu_stall[g]),
      .cpu_dv   (cpu_dv[g]),
      .ro_req   (ro_req),
      .ro_addr  (ro_addr),
      .ro_gnt   (ro_gnt[g]),
      .ro_data  (ro_data[g]),
      .ro_valid (ro_valid[g]),
      .ram_en   (ram_en[g]),
      .ram_we   (ram_we[g]),
      .ram_a    (ram_a[g]),
      .ram_di   (ram_di[g]),
      .ram_do   (ram_do[g])
    );

    // DFFRAM: registered read data, byte-masked writes.
    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      end else if (ram_en[g]) begin
        if (ram_we[g] == 4'b0000) begin
          ram_do[g] <= mem[ram_a[g]];
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (ram_we[g][b]) mem[ram_a[g]][8*b +: 8] <= ram_di[g][8*b +: 8];
          end
        end
      end
    end
  end

  // Reference model state, per mode
  logic [31:0] ref_mem [2][256];
  int          denied  [2];
  bit          last_ro [2];
  bit          pend_cpu[2], pend_ro[2];
  logic [31:0] pend_cpu_data[2], pend_ro_data[2], ro_hold[2];
  bit          exp_rg[2], exp_cg[2];
  int          nchecks, nerrors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int m);
    denied[m]   = 0;
    last_ro[m]  = 1'b1;
    pend_cpu[m] = 1'b0;
    pend_ro[m]  = 1'b0;
    ro_hold[m]  = '0;
  endtask

  task automatic model_check();
    for (int m = 0; m < 2; m++) begin
      bit wins, eg, ecg;
      // MODE 0: RO wins once denied SM cycles in a row; MODE 1: whoever did not go last wins.
      wins = (m == 0) ? (denied[m] == SM) : !last_ro[m];
      eg   = ro_req && (wins || !cpu_en);
      ecg  = cpu_en && !eg;
      exp_rg[m] = eg;
      exp_cg[m] = ecg;
      chk($sformatf("m%0d ro_gnt", m), 32'(ro_gnt[m]), 32'(eg));
      chk($sformatf("m%0d cpu_stall", m), 32'(cpu_stall[m]), 32'(cpu_en && eg));
      chk($sformatf("m%0d ram_en", m), 32'(ram_en[m]), 32'(eg || ecg));
      chk($sformatf("m%0d ram_we", m), 32'(ram_we[m]), ecg ? 32'(cpu_we) : 32'd0);
      chk($sformatf("m%0d ram_a", m), 32'(ram_a[m]),
          eg ? 32'(ro_addr) : (ecg ? 32'(cpu_a) : 32'd0));
      chk($sformatf("m%0d ram_di", m), ram_di[m], ecg ? cpu_di : 32'd0);
      chk($sformatf("m%0d cpu_dv", m), 32'(cpu_dv[m]), 32'(pend_cpu[m]));
      if (pend_cpu[m]) chk($sformatf("m%0d cpu_do", m), cpu_do[m], pend_cpu_data[m]);
      chk($sformatf("m%0d ro_valid", m), 32'(ro_valid[m]), 32'(pend_ro[m]));
      chk($sformatf("m%0d ro_data", m), ro_data[m], pend_ro[m] ? pend_ro_data[m] : ro_hold[m]);
    end
  endtask

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      logic [31:0] rd_c, rd_r;
      rd_c = ref_mem[m][cpu_a];
      rd_r = ref_mem[m][ro_addr];
      if (exp_cg[m] && cpu_we != 4'b0000) begin
        for (int b = 0; b < 4; b++) begin
          if (cpu_we[b]) ref_mem[m][cpu_a][8*b +: 8] = cpu_di[8*b +: 8];
        end
      end
      if (!rstn) begin
        model_reset(m);
      end else begin
        if (pend_ro[m]) ro_hold[m] = pend_ro_data[m];
        pend_cpu[m]      = exp_cg[m] && (cpu_we == 4'b0000);
        pend_cpu_data[m] = rd_c;
        pend_ro[m]       = exp_rg[m];
        pend_ro_data[m]  = rd_r;
        denied[m]        = (ro_req && !exp_rg[m]) ? ((denied[m] < SM) ? denied[m] + 1 : SM) : 0;
        if (exp_rg[m]) last_ro[m] = 1'b1;
        else if (exp_cg[m]) last_ro[m] = 1'b0;
      end
    end
  endtask

  // Called just after a rising edge: drive, settle, check against the model.
  task automatic apply(input logic r, input logic en, input logic [3:0] we, input logic [7:0] a,
                       input logic [31:0] di, input logic req, input logic [7:0] ra);
    rstn    = r;
    cpu_en  = en;
    cpu_we  = we;
    cpu_a   = a;
    cpu_di  = di;
    ro_req  = req;
    ro_addr = ra;
    if (!r) begin
      model_reset(0);
      model_reset(1);
    end
    #3;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        r, en;
    logic [3:0]  we;
    logic [7:0]  a;
    logic [31:0] di;
    logic        req;
    logic [7:0]  ra;
    logic        gnt, stall, dv;
    logic [31:0] dout;
    logic        val;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [3:0] we, input logic [7:0] a,
                              input logic [31:0] di, input logic req, input logic [7:0] ra,
                              input logic gnt, input logic stall, input logic dv,
                              input logic [31:0] dout, input logic val, input logic [31:0] rdata);
    vec_t v;
    v.r = 1'b1; v.en = en; v.we = we; v.a = a; v.di = di; v.req = req; v.ra = ra;
    v.gnt = gnt; v.stall = stall; v.dv = dv; v.dout = dout; v.val = val; v.rdata = rdata;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    nchecks  = 0;
    nerrors  = 0;
    mem_init = 1'b1;
    rstn     = 1'b0;
    cpu_en   = 1'b0;
    cpu_we   = '0;
    cpu_a    = '0;
    cpu_di   = '0;
    ro_req   = 1'b0;
    ro_addr  = '0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 256; i++) ref_mem[m][i] = pat(i);
      model_reset(m);
    end
    @(posedge clk);
    #1;
    mem_init = 1'b0;

    // Reset held with both requesters active
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h20);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rst m%0d cpu_dv", m), 32'(cpu_dv[m]), 32'd0);
        chk($sformatf("rst m%0d ro_valid", m), 32'(ro_valid[m]), 32'd0);
        chk($sformatf("rst m%0d ro_data", m), ro_data[m], 32'd0);
      end
      advance();
    end

    // MODE 0 directed table: byte write, starvation, RO-only back-to-back
    //              en  we    a      di            req ra     gnt stl dv  dout          val rdata
    vecs.push_back(mk(1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 8'h00, 0, 0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 4'h1, 8'h10, 32'h000000AA, 0, 8'h00, 0, 0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 4'h0, 8'h10, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0, 0, 1, 32'hDEADBEAA, 0, 32'h0));
    vecs.push_back(mk(1, 4'h0, 8'h20, 32'h0,        1, 8'h10, 0, 0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 4'h0, 8'h20, 32'h0,        1, 8'h10, 0, 0, 1, pat(8'h20),   0, 32'h0));
    vecs.push_back(mk(1, 4'h0, 8'h20, 32'h0,        1, 8'h10, 0, 0, 1, pat(8'h20),   0, 32'h0));
    vecs.push_back(mk(1, 4'h0, 8'h20, 32'h0,        1, 8'h10, 0, 0, 1, pat(8'h20),   0, 32'h0));
    vecs.push_back(mk(1, 4'h0, 8'h20, 32'h0,        1, 8'h10, 1, 1, 1, pat(8'h20),   0, 32'h0));
    vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0,        1, 32'hDEADBEAA));
    vecs.push_back(mk(1, 4'h0, 8'h20, 32'h0,        1, 8'h10, 0, 0, 0, 32'h0,        0, 32'hDEADBEAA));
    vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0, 0, 1, pat(8'h20),   0, 32'hDEADBEAA));
    vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0,        1, 8'h00, 1, 0, 0, 32'h0,        0, 32'hDEADBEAA));
    vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0,        1, 8'hFF, 1, 0, 0, 32'h0,        1, pat(8'h00)));
    vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0,        1, pat(8'hFF)));
    vecs.push_back(mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0,        0, pat(8'hFF)));
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].di, vecs[i].req, vecs[i].ra);
      chk($sformatf("vec%0d ro_gnt", i), 32'(ro_gnt[0]), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d cpu_stall", i), 32'(cpu_stall[0]), 32'(vecs[i].stall));
      chk($sformatf("vec%0d cpu_dv", i), 32'(cpu_dv[0]), 32'(vecs[i].dv));
      if (vecs[i].dv) chk($sformatf("vec%0d cpu_do", i), cpu_do[0], vecs[i].dout);
      chk($sformatf("vec%0d ro_valid", i), 32'(ro_valid[0]), 32'(vecs[i].val));
      chk($sformatf("vec%0d ro_data", i), ro_data[0], vecs[i].rdata);
      advance();
    end

    // MODE 1 round-robin after a fresh reset: CPU first, then strict alternation
    apply(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
    advance();
    for (int c = 0; c < 6; c++) begin
      apply(1'b1, 1'b1, 4'h0, 8'h10, 32'h0, 1'b1, 8'h00);
      chk($sformatf("rr%0d ro_gnt", c), 32'(ro_gnt[1]), 32'(c % 2));
      chk($sformatf("rr%0d cpu_dv", c), 32'(cpu_dv[1]), 32'(c > 0 && (c - 1) % 2 == 0));
      chk($sformatf("rr%0d ro_valid", c), 32'(ro_valid[1]), 32'(c > 0 && (c - 1) % 2 == 1));
      if (c > 0 && (c - 1) % 2 == 0) chk($sformatf("rr%0d cpu_do", c), cpu_do[1], 32'hDEADBEAA);
      if (c > 0 && (c - 1) % 2 == 1) chk($sformatf("rr%0d ro_data", c), ro_data[1], pat(8'h00));
      advance();
    end

    // Reset lands the cycle after an accepted CPU read: the dv pulse is dropped
    apply(1'b1, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h00);
    advance();
    apply(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("midrst m%0d cpu_dv", m), 32'(cpu_dv[m]), 32'd0);
      chk($sformatf("midrst m%0d ro_data", m), ro_data[m], 32'd0);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("postrst%0d m%0d cpu_dv", k, m), 32'(cpu_dv[m]), 32'd0);
        chk($sformatf("postrst%0d m%0d ro_valid", k, m), 32'(ro_valid[m]), 32'd0);
      end
      advance();
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic        r, en, req;
      logic [3:0]  we;
      logic [7:0]  a, ra;
      r   = ($urandom_range(0, 299) != 0);
      en  = ($urandom_range(0, 3) != 0);
      req = ($urandom_range(0, 2) != 0);
      we  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      a   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      ra  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      apply(r, en, we, a, 32'($urandom), req, ra);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
